// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, default width and FSM states shared by the execute-stage ALU units
package alu_pkg;

  localparam int WORDSIZE_DEF = 32;
  localparam int OPSIZE       = 3;

  localparam logic [OPSIZE-1:0] OP_MUL    = 3'd0;
  localparam logic [OPSIZE-1:0] OP_MULH   = 3'd1;
  localparam logic [OPSIZE-1:0] OP_MULHSU = 3'd2;
  localparam logic [OPSIZE-1:0] OP_MULHU  = 3'd3;
  localparam logic [OPSIZE-1:0] OP_DIV    = 3'd4;
  localparam logic [OPSIZE-1:0] OP_DIVU   = 3'd5;
  localparam logic [OPSIZE-1:0] OP_REM    = 3'd6;
  localparam logic [OPSIZE-1:0] OP_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter_if.sv
// rtl/alu_muldiv_iter_if.sv - request/response handshake bundle of the iterative mul/div unit
interface alu_muldiv_iter_if #(
  parameter int WORDSIZE = alu_pkg::WORDSIZE_DEF,
  parameter int OPSIZE   = alu_pkg::OPSIZE
);
  logic                kill;
  logic                in_valid;
  logic                in_ready;
  logic [OPSIZE-1:0]   op;
  logic [WORDSIZE-1:0] a;
  logic [WORDSIZE-1:0] b;
  logic                out_valid;
  logic                out_ready;
  logic [WORDSIZE-1:0] out;
  logic                z;
  logic                n;

  modport master (
    output kill, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, z, n
  );

  modport slave (
    input  kill, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, z, n
  );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: shift-add multiply or restoring divide
module muldiv_step
  import alu_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_DEF
) (
  input  logic                    is_div,
  input  logic [2*WORDSIZE-1:0]   acc_i,
  input  logic [WORDSIZE-1:0]     opnd,
  output logic [2*WORDSIZE-1:0]   acc_o
);

  logic [WORDSIZE-1:0] addend;
  logic [WORDSIZE:0]   sum;
  logic [WORDSIZE:0]   rem_sh;
  logic [WORDSIZE:0]   diff;

  // mul: acc = {partial product, remaining multiplier bits}; div: acc = {remainder, dividend/quotient}
  always_comb begin
    addend = acc_i[0] ? opnd : '0;
    sum    = {1'b0, acc_i[2*WORDSIZE-1:WORDSIZE]} + {1'b0, addend};
    rem_sh = acc_i[2*WORDSIZE-1:WORDSIZE-1];
    diff   = rem_sh - {1'b0, opnd};
    if (is_div) begin
      if (diff[WORDSIZE]) acc_o = {rem_sh[WORDSIZE-1:0], acc_i[WORDSIZE-2:0], 1'b0};
      else                acc_o = {diff[WORDSIZE-1:0], acc_i[WORDSIZE-2:0], 1'b1};
    end else begin
      acc_o = {sum, acc_i[WORDSIZE-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative RV32M multiply/divide unit with valid/ready handshake and kill
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_DEF,
  parameter int UNROLL   = 1
) (
  input logic              clk,
  input logic              rst_n,
  alu_muldiv_iter_if.slave bus
);

  localparam int STEPS = WORDSIZE / UNROLL;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [WORDSIZE-1:0] MIN_VAL = {1'b1, {(WORDSIZE-1){1'b0}}};

  state_e                state_q, state_d;
  logic [OPSIZE-1:0]     op_q, op_d;
  logic [WORDSIZE-1:0]   a_q, a_d, b_q, b_d, opnd_q, opnd_d, out_q, out_d;
  logic [2*WORDSIZE-1:0] acc_q, acc_d;
  logic                  neg_q, neg_d, z_q, z_d, n_q, n_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  sgn_a, sgn_b, a_neg, b_neg, load_out;
  logic [WORDSIZE-1:0]   mag_a, mag_b, qr_res, res;
  logic [2*WORDSIZE-1:0] prod;
  logic [2*WORDSIZE-1:0] chain [UNROLL+1];

  assign chain[0] = acc_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    muldiv_step #(.WORDSIZE(WORDSIZE)) u_step (
      .is_div (op_q[2]),
      .acc_i  (chain[g]),
      .opnd   (opnd_q),
      .acc_o  (chain[g+1])
    );
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    z_d      = z_q;
    n_d      = n_q;
    load_out = 1'b0;
    res      = '0;

    sgn_a  = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
    sgn_b  = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    a_neg  = sgn_a & a_q[WORDSIZE-1];
    b_neg  = sgn_b & b_q[WORDSIZE-1];
    mag_a  = a_neg ? -a_q : a_q;
    mag_b  = b_neg ? -b_q : b_q;
    prod   = neg_q ? -acc_q : acc_q;
    qr_res = op_q[1] ? acc_q[2*WORDSIZE-1:WORDSIZE] : acc_q[WORDSIZE-1:0];
    if (neg_q) qr_res = -qr_res;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        if (op_q[2] && (b_q == '0)) begin
          res      = op_q[1] ? a_q : '1;
          load_out = 1'b1;
          state_d  = ST_DONE;
        end else if (((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == MIN_VAL) && (b_q == '1)) begin
          res      = op_q[1] ? '0 : MIN_VAL;
          load_out = 1'b1;
          state_d  = ST_DONE;
        end else begin
          // the remainder follows the dividend's sign, everything else the xor of both
          acc_d   = {{WORDSIZE{1'b0}}, (op_q[2] ? mag_a : mag_b)};
          opnd_d  = op_q[2] ? mag_b : mag_a;
          neg_d   = (op_q == OP_REM) ? a_neg : (a_neg ^ b_neg);
          cnt_d   = CNT_W'(STEPS - 1);
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = chain[UNROLL];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (op_q[2])             res = qr_res;
        else if (op_q == OP_MUL) res = prod[WORDSIZE-1:0];
        else                     res = prod[2*WORDSIZE-1:WORDSIZE];
        load_out = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_out) begin
      out_d = res;
      z_d   = (res == '0);
      n_d   = res[WORDSIZE-1];
    end

    if (bus.kill) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out       = out_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;

endmodule
